dispatch_sequencer: RTL and testbench

DISPATCH_SEQUENCER -- requirements
Module: dispatch_sequencer

---
 rtl/dispatch_sequencer.sv | 135 +++++++++++++
 tb/tb_dispatch_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_sequencer.sv
// Instruction dispatcher: sequences RUN / SPK / SNC / CLR commands onto the network and sink.
// Optional run-time counter is built when DISPATCH_SEQUENCER_TIME_EN is defined.
module dispatch_sequencer #(
  parameter int OPERAND_WIDTH = 16,
  parameter int TIME_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [1:0]               instr_opc,
  input  logic [OPERAND_WIDTH-1:0] instr_operand,
  output logic                     net_run,
  output logic                     net_clear,
  output logic                     spk_valid,
  input  logic                     spk_ready,
  output logic [OPERAND_WIDTH-1:0] spk_data,
  input  logic                     sink_idle,
  output logic                     flg_valid,
  input  logic                     flg_ready,
  output logic [1:0]               flg,
  output logic [TIME_WIDTH-1:0]    run_time
);

  typedef enum logic [1:0] {
    OPC_RUN = 2'd0,
    OPC_SPK = 2'd1,
    OPC_SNC = 2'd2,
    OPC_CLR = 2'd3
  } opc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SPK,
    ST_SNC_WAIT,
    ST_FLAG,
    ST_CLR
  } state_t;

  localparam logic [OPERAND_WIDTH-1:0] CNT_ONE = OPERAND_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [OPERAND_WIDTH-1:0] cnt_q;
  logic                     cnt_load, spk_load, flg_load;
  logic [1:0]               flg_d;

  // NOTE: async reset in the sensitivity list, non-blocking assignments for all state.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    spk_load = 1'b0;
    flg_load = 1'b0;
    flg_d    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          case (opc_t'(instr_opc))
            OPC_RUN: begin
              // A zero-length run is consumed in place.
              if (instr_operand != '0) begin
                state_d  = ST_RUN;
                cnt_load = 1'b1;
              end
            end
            OPC_SPK: begin
              state_d  = ST_SPK;
              spk_load = 1'b1;
            end
            OPC_SNC: state_d = ST_SNC_WAIT;
            OPC_CLR: state_d = ST_CLR;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN:      if (cnt_q == CNT_ONE) state_d = ST_IDLE;
      ST_SPK:      if (spk_ready) state_d = ST_IDLE;
      ST_SNC_WAIT: begin
        if (sink_idle) begin
          state_d  = ST_FLAG;
          flg_load = 1'b1;
          flg_d    = 2'b01;
        end
      end
      ST_CLR: begin
        state_d  = ST_FLAG;
        flg_load = 1'b1;
        flg_d    = 2'b10;
      end
      ST_FLAG:     if (flg_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q    <= '0;
      spk_data <= '0;
      flg      <= 2'b00;
    end else begin
      if (cnt_load)              cnt_q <= instr_operand;
      else if (state_q == ST_RUN) cnt_q <= cnt_q - CNT_ONE;
      if (spk_load) spk_data <= instr_operand;
      if (flg_load) flg      <= flg_d;
    end
  end

  // Strobes decode straight from state so reset removes them without a clock edge.
  assign instr_ready = (state_q == ST_IDLE);
  assign net_run     = (state_q == ST_RUN);
  assign net_clear   = (state_q == ST_CLR);
  assign spk_valid   = (state_q == ST_SPK);
  assign flg_valid   = (state_q == ST_FLAG);

`ifdef DISPATCH_SEQUENCER_TIME_EN
  logic [TIME_WIDTH-1:0] time_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)           time_q <= '0;
    else if (net_clear) time_q <= '0;
    else if (net_run)   time_q <= time_q + TIME_WIDTH'(1);
  end

  assign run_time = time_q;
`else
  assign run_time = '0;
`endif

endmodule

// File: tb/tb_dispatch_sequencer.sv
// Scoreboard bench for dispatch_sequencer: directed cases then randomized instruction streams.
module tb_dispatch_sequencer;
  localparam int OW = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          arst;
  logic          instr_valid, instr_ready;
  logic [1:0]    instr_opc;
  logic [OW-1:0] instr_operand;
  logic          net_run, net_clear;
  logic          spk_valid, spk_ready;
  logic [OW-1:0] spk_data;
  logic          sink_idle;
  logic          flg_valid, flg_ready;
  logic [1:0]    flg;
  logic [TW-1:0] run_time;

  dispatch_sequencer #(.OPERAND_WIDTH(OW), .TIME_WIDTH(TW)) dut (
    .clk(clk), .arst(arst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opc(instr_opc), .instr_operand(instr_operand),
    .net_run(net_run), .net_clear(net_clear),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_data(spk_data),
    .sink_idle(sink_idle),
    .flg_valid(flg_valid), .flg_ready(flg_ready), .flg(flg),
    .run_time(run_time)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int            run_q[$];
  logic [OW-1:0] spk_q[$];
  logic [1:0]    flg_q[$];
  int            exp_clr = 0;
  int            seen_clr = 0;
  int            exp_time = 0;
  bit            rand_hs = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue the observable effect of each instruction, and keep
  // run_time as the total of run lengths since the last CLR, modulo 2^TW.
  task automatic issue(input logic [1:0] opc, input logic [OW-1:0] opd);
    int budget = 2000;
    instr_valid   = 1'b1;
    instr_opc     = opc;
    instr_operand = opd;
    while (!instr_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!instr_ready) begin
      check("instr_ready_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    check("run_time_at_issue", run_time, exp_time);
    case (opc)
      2'd0: begin
        if (opd != 0) run_q.push_back(int'(opd));
`ifdef DISPATCH_SEQUENCER_TIME_EN
        exp_time = (exp_time + int'(opd)) % (1 << TW);
`endif
      end
      2'd1: spk_q.push_back(opd);
      2'd2: flg_q.push_back(2'b01);
      default: begin
        flg_q.push_back(2'b10);
        exp_clr++;
        exp_time = 0;
      end
    endcase
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // Random back-pressure, changed just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_hs) begin
        spk_ready = 1'($urandom_range(0, 1));
        flg_ready = 1'($urandom_range(0, 1));
        sink_idle = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents a transfer or finishes a run burst.
  initial begin
    int            run_len = 0;
    logic          prev_clr = 1'b0;
    logic          spk_pend = 1'b0;
    logic [OW-1:0] spk_prev = '0;
    logic          flg_pend = 1'b0;
    logic [1:0]    flg_prev = '0;
    forever begin
      @(negedge clk);
      #1;
      if (arst) begin
        run_len  = 0;
        prev_clr = 1'b0;
        spk_pend = 1'b0;
        flg_pend = 1'b0;
        continue;
      end
      check("mutex", (int'(net_run) + int'(net_clear) + int'(spk_valid) + int'(flg_valid)) <= 1, 1);
      if (net_run) run_len++;
      else if (run_len > 0) begin
        if (run_q.size() == 0) check("run_unexpected", run_len, 0);
        else check("run_len", run_len, run_q.pop_front());
        run_len = 0;
      end
      if (net_clear) begin
        seen_clr++;
        check("clr_single_cycle", prev_clr, 0);
      end
      prev_clr = net_clear;
      if (spk_valid && spk_pend) check("spk_data_stable", spk_data, spk_prev);
      if (spk_valid && spk_ready) begin
        if (spk_q.size() == 0) check("spk_unexpected", spk_data, 0);
        else check("spk_data", spk_data, spk_q.pop_front());
      end
      spk_pend = spk_valid && !spk_ready;
      spk_prev = spk_data;
      if (flg_valid && flg_pend) check("flg_stable", flg, flg_prev);
      if (flg_valid && flg_ready) begin
        if (flg_q.size() == 0) check("flg_unexpected", flg, 0);
        else check("flg", flg, flg_q.pop_front());
      end
      flg_pend = flg_valid && !flg_ready;
      flg_prev = flg;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    r_opc;
    logic [OW-1:0] r_opd;
    int            budget;
    arst = 1'b1; instr_valid = 1'b0; instr_opc = '0; instr_operand = '0;
    spk_ready = 1'b1; flg_ready = 1'b1; sink_idle = 1'b1;
    #12;
    check("rst_net_run", net_run, 0);
    check("rst_outputs", {net_clear, spk_valid, flg_valid, flg, spk_data, run_time}, 0);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1 check("rst_instr_ready", instr_ready, 1);

    // RUN 5: five consecutive net_run cycles with instr_ready low.
    issue(2'd0, 8'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("run5_net_run", net_run, 1);
      check("run5_instr_ready", instr_ready, 0);
    end
    @(negedge clk);
    check("run5_end", {net_run, instr_ready}, 2'b01);

    // RUN 0 then SPK accepted straight away, with spk_ready low for 3 cycles.
    spk_ready = 1'b0;
    issue(2'd0, 8'd0);
    check("run0_instr_ready", instr_ready, 1);
    issue(2'd1, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spk_valid_wait", {spk_valid, spk_data}, {1'b1, 8'hA5});
      check("run0_no_net_run", net_run, 0);
    end
    @(negedge clk);
    check("spk_valid_last", spk_valid, 1);
    spk_ready = 1'b1;
    @(negedge clk);
    check("spk_done", spk_valid, 0);

    // SNC with the sink busy for 4 cycles, then flag held until flg_ready.
    sink_idle = 1'b0;
    flg_ready = 1'b0;
    issue(2'd2, 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("snc_wait_no_flag", flg_valid, 0);
    end
    sink_idle = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("snc_flag", {flg_valid, flg}, 3'b101);
    end
    flg_ready = 1'b1;
    @(negedge clk);
    check("snc_flag_done", flg_valid, 0);

    // CLR, RUN 3, CLR: single net_clear pulse then a 10 flag.
    issue(2'd3, 8'd0);
    issue(2'd0, 8'd3);
    issue(2'd3, 8'd0);
    @(negedge clk);
    check("clr_pulse", {net_clear, flg_valid}, 2'b10);
    @(negedge clk);
    check("clr_flag", {net_clear, flg_valid, flg}, 4'b0110);

    // Largest run count, then one more run to wrap run_time.
    issue(2'd0, 8'd255);
    issue(2'd0, 8'd3);

    // Reset in the middle of a long run.
    issue(2'd0, 8'd100);
    repeat (10) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    check("arst_net_run", net_run, 0);
    check("arst_outputs", {net_clear, spk_valid, flg_valid, flg, spk_data, run_time}, 0);
    run_q.delete(); spk_q.delete(); flg_q.delete();
    exp_time = 0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1 check("arst_release_ready", {instr_ready, net_run}, 2'b10);

    // Randomized instruction stream under random back-pressure.
    rand_hs = 1'b1;
    for (int n = 0; n < 80; n++) begin
      r_opc = 2'($urandom_range(0, 3));
      r_opd = (r_opc == 2'd0) ? OW'($urandom_range(0, 12)) : OW'($urandom);
      issue(r_opc, r_opd);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rand_hs = 1'b0;
    spk_ready = 1'b1; flg_ready = 1'b1; sink_idle = 1'b1;
    budget = 2000;
    while ((!instr_ready || run_q.size() || spk_q.size() || flg_q.size()) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (2) @(negedge clk);
    check("drain_run_q", run_q.size(), 0);
    check("drain_spk_q", spk_q.size(), 0);
    check("drain_flg_q", flg_q.size(), 0);
    check("clr_count", seen_clr, exp_clr);
    check("final_run_time", run_time, exp_time);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
